// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - data_bus address map, STATUS bit positions and address decode
package bus_pkg;

  localparam logic [7:0] ADDR_TXDATA = 8'hF0;
  localparam logic [7:0] ADDR_STATUS = 8'hF1;
  localparam logic [7:0] ADDR_TIMER  = 8'hF2;
  localparam logic [7:0] ADDR_LEDS   = 8'hF3;

  localparam int STAT_FULL     = 0;
  localparam int STAT_EMPTY    = 1;
  localparam int STAT_EXPIRED  = 2;
  localparam int STAT_OVERFLOW = 3;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_TXDATA,
    SEL_STATUS,
    SEL_TIMER,
    SEL_LEDS,
    SEL_NONE
  } sel_e;

  // Addresses above ram_top that are not a named register fall to SEL_NONE (read 0, writes ignored).
  function automatic sel_e decode_addr(input logic [7:0] addr, input logic [7:0] ram_top);
    sel_e sel;
    sel = SEL_NONE;
    if (addr <= ram_top) begin
      sel = SEL_RAM;
    end else begin
      case (addr)
        ADDR_TXDATA: sel = SEL_TXDATA;
        ADDR_STATUS: sel = SEL_STATUS;
        ADDR_TIMER:  sel = SEL_TIMER;
        ADDR_LEDS:   sel = SEL_LEDS;
        default:     sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// rtl/tx_fifo.sv - TX byte FIFO; push while full is taken only if the same edge also pops
module tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] pushData,
  input  logic       pop,
  output logic [7:0] headData,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_pop;
  logic          do_push;

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign headData = mem[rd_ptr];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= pushData;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/data_bus.sv
// rtl/data_bus.sv - CPU data bus: RAM, TX FIFO, STATUS, LEDs; timer present only with DATA_BUS_TIMER_EN
module data_bus
  import bus_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] RAM_TOP    = 8'hEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] memAddress,
  input  logic [7:0] memIn,
  input  logic       memWrEnable,
  output logic [7:0] memOut,
  output logic [7:0] txData,
  output logic       txValid,
  input  logic       txReady,
  output logic [7:0] leds
);

  sel_e       sel;
  logic       ram_wr;
  logic       status_wr;
  logic       leds_wr;
  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic       overflow;
  logic       ovf_set;
  logic       expired_bit;
  logic [7:0] timer_rd;
  logic [7:0] status;
  logic [7:0] ram [0:RAM_TOP];

  assign sel       = decode_addr(memAddress, RAM_TOP);
  assign ram_wr    = memWrEnable && !rst && (sel == SEL_RAM);
  assign status_wr = memWrEnable && (sel == SEL_STATUS);
  assign leds_wr   = memWrEnable && (sel == SEL_LEDS);
  assign fifo_push = memWrEnable && (sel == SEL_TXDATA);
  assign fifo_pop  = txValid && txReady;
  assign txValid   = !fifo_empty;
  assign ovf_set   = fifo_push && fifo_full && !fifo_pop;

  tx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_tx_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .pushData (memIn),
    .pop      (fifo_pop),
    .headData (txData),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (ram_wr) begin
      ram[memAddress] <= memIn;
    end
  end

  // Sticky flags: a set on the same edge as a software clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      leds     <= 8'h00;
    end else begin
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (status_wr && memIn[STAT_OVERFLOW]) begin
        overflow <= 1'b0;
      end
      if (leds_wr) begin
        leds <= memIn;
      end
    end
  end

`ifdef DATA_BUS_TIMER_EN
  logic [7:0] tmr_count;
  logic [7:0] tmr_reload;
  logic       expired;
  logic       timer_wr;
  logic       exp_set;

  assign timer_wr = memWrEnable && (sel == SEL_TIMER);
  assign exp_set  = !timer_wr && (tmr_count == 8'd1);

  // Reload on the 1->0 step so the period equals the reload value.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_count  <= 8'h00;
      tmr_reload <= 8'h00;
      expired    <= 1'b0;
    end else begin
      if (timer_wr) begin
        tmr_count  <= memIn;
        tmr_reload <= memIn;
      end else if (tmr_count == 8'd1) begin
        tmr_count <= tmr_reload;
      end else if (tmr_count != 8'd0) begin
        tmr_count <= tmr_count - 8'd1;
      end
      if (exp_set) begin
        expired <= 1'b1;
      end else if (status_wr && memIn[STAT_EXPIRED]) begin
        expired <= 1'b0;
      end
    end
  end

  assign timer_rd    = tmr_count;
  assign expired_bit = expired;
`else
  assign timer_rd    = 8'h00;
  assign expired_bit = 1'b0;
`endif

  always_comb begin
    status                = 8'h00;
    status[STAT_FULL]     = fifo_full;
    status[STAT_EMPTY]    = fifo_empty;
    status[STAT_EXPIRED]  = expired_bit;
    status[STAT_OVERFLOW] = overflow;
  end

  always_comb begin
    memOut = 8'h00;
    case (sel)
      SEL_RAM:    memOut = ram[memAddress];
      SEL_STATUS: memOut = status;
      SEL_TIMER:  memOut = timer_rd;
      SEL_LEDS:   memOut = leds;
      default:    memOut = 8'h00;
    endcase
  end

endmodule
